// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one cache request per instruction, stall on miss.
// Optional watchdog built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] aluout_i,
    input  logic [31:0] rdat2_i,
    input  logic        dREN_i,
    input  logic        dWEN_i,
    input  logic        halt_i,
    input  logic        freeze,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic [31:0] loaddata_o,
    output logic        halt_o,
    output logic [31:0] stall_cnt,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        memop;
    logic        active;
    logic        tmo;
    logic [31:0] held_data;

    assign memop  = dREN_i | dWEN_i;
    assign active = (state != HOLD);

    assign dmemREN   = dREN_i & active & ~flush;
    assign dmemWEN   = dWEN_i & active & ~flush;
    assign dmemaddr  = aluout_i;
    assign dmemstore = rdat2_i;
    assign mem_stall = memop & ~dhit & active & ~flush;

    assign loaddata_o = (state == HOLD) ? held_data : dmemload;

`ifdef MEM_TIMEOUT_EN
    localparam int WCW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WCW     = (WCW_RAW > 8) ? WCW_RAW : 8;

    logic [WCW-1:0] wait_cnt;
    logic           tmo_q;

    // Wait counter: zero outside ACCESS, counts each ACCESS cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Last permitted ACCESS cycle without a hit trips the watchdog
    assign tmo = (state == ACCESS) & ~dhit & ~flush &
                 (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));

    // Sticky watchdog error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_q <= 1'b0;
        end else if (tmo) begin
            tmo_q <= 1'b1;
        end
    end

    assign timeout_err = tmo_q;
`else
    // No watchdog: ACCESS waits for the cache indefinitely
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (memop) begin
                        if (!dhit) begin
                            state_n = ACCESS;
                        end else if (freeze) begin
                            state_n = HOLD;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state_n = freeze ? HOLD : IDLE;
                    end else if (tmo) begin
                        state_n = IDLE;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Capture load data when the cache completes a live read
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            held_data <= '0;
        end else if (dhit & dREN_i & active & ~flush) begin
            held_data <= dmemload;
        end
    end

    // Sticky halt once the halting instruction leaves MEM
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_o <= 1'b0;
        end else if (halt_i & ~flush & ~mem_stall) begin
            halt_o <= 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
